// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between a single-issue core and a simple
// valid/ready request bus with a separate read-data return (rvalid/rdata).
// Handles byte/half/word sizing, store lane replication, load extension,
// misalignment faults and a bounded bus wait with abort.
module mem_access_unit #(
    parameter int WORD_SIZE = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [WORD_SIZE-1:0] i_Addr,
    input  logic [WORD_SIZE-1:0] i_Wd,
    input  logic                 i_Wen,
    input  logic                 i_Ren,
    input  logic [2:0]           i_Funct3,
    output logic [WORD_SIZE-1:0] o_Rd,
    output logic                 o_Stall,
    output logic                 o_Fault,
    output logic                 o_Timeout,
    output logic [WORD_SIZE-1:0] o_Bus_addr,
    output logic [WORD_SIZE-1:0] o_Bus_wdata,
    output logic [3:0]           o_Bus_be,
    output logic                 o_Bus_we,
    output logic                 o_Bus_valid,
    input  logic                 i_Bus_ready,
    input  logic                 i_Bus_rvalid,
    input  logic [WORD_SIZE-1:0] i_Bus_rdata
);

    // Counter is wide enough to hold TIMEOUT-1 with headroom.
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [CW-1:0]          cnt_reg;
    logic [WORD_SIZE-3:0]   addr_hi_reg;
    logic [1:0]             off_reg;
    logic [2:0]             f3_reg;
    logic [WORD_SIZE-1:0]   wdata_reg;
    logic [3:0]             be_reg;
    logic                   we_reg;
    logic [WORD_SIZE-1:0]   rd_reg;
    logic                   timeout_reg;

    logic                   is_req;
    logic                   size_bad;
    logic                   illegal;
    logic                   legal_req;
    logic [3:0]             be_next;
    logic [WORD_SIZE-1:0]   wdata_next;
    logic [WORD_SIZE-1:0]   load_ext;
    logic [7:0]             load_byte;
    logic [15:0]            load_half;
    logic                   capture;
    logic                   timeout_hit;

    // Request decode: size/sign legality and alignment for the incoming access.
    always_comb begin
        is_req   = i_Wen ^ i_Ren;
        size_bad = 1'b1;
        case (i_Funct3)
            3'b000:  size_bad = 1'b0;
            3'b001:  size_bad = i_Addr[0];
            3'b010:  size_bad = (i_Addr[1:0] != 2'b00);
            3'b100:  size_bad = i_Wen;
            3'b101:  size_bad = i_Wen | i_Addr[0];
            default: size_bad = 1'b1;
        endcase
        illegal   = (i_Wen & i_Ren) | (is_req & size_bad);
        legal_req = (state_reg == S_IDLE) & is_req & ~size_bad;
        o_Fault   = (state_reg == S_IDLE) & illegal;
    end

    // Byte enables and store-data lane replication for the incoming access.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = i_Wd;
        case (i_Funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << i_Addr[1:0];
                wdata_next = {4{i_Wd[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << i_Addr[1:0];
                wdata_next = {2{i_Wd[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = i_Wd;
            end
        endcase
    end

    // Load extraction from the returned word using the latched offset/size.
    always_comb begin
        load_byte = i_Bus_rdata[{off_reg, 3'b000} +: 8];
        load_half = i_Bus_rdata[{off_reg[1], 4'b0000} +: 16];
        case (f3_reg)
            3'b000:  load_ext = {{(WORD_SIZE-8){load_byte[7]}}, load_byte};
            3'b001:  load_ext = {{(WORD_SIZE-16){load_half[15]}}, load_half};
            3'b100:  load_ext = {{(WORD_SIZE-8){1'b0}}, load_byte};
            3'b101:  load_ext = {{(WORD_SIZE-16){1'b0}}, load_half};
            default: load_ext = i_Bus_rdata;
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; completion takes priority over the timeout abort.
    always_comb begin
        state_next  = state_reg;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (legal_req) state_next = S_REQ;
            end
            S_REQ: begin
                if (i_Bus_ready) begin
                    state_next = we_reg ? S_DONE : S_WAIT_R;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next  = S_DONE;
                    timeout_hit = 1'b1;
                end
            end
            S_WAIT_R: begin
                if (i_Bus_rvalid) begin
                    state_next = S_DONE;
                    capture    = 1'b1;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next  = S_DONE;
                    timeout_hit = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Request latch, wait counter, load result and abort flag.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_reg     <= '0;
            addr_hi_reg <= '0;
            off_reg     <= 2'b00;
            f3_reg      <= 3'b000;
            wdata_reg   <= '0;
            be_reg      <= 4'b0000;
            we_reg      <= 1'b0;
            rd_reg      <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= timeout_hit;
            if (legal_req) begin
                cnt_reg     <= '0;
                addr_hi_reg <= i_Addr[WORD_SIZE-1:2];
                off_reg     <= i_Addr[1:0];
                f3_reg      <= i_Funct3;
                wdata_reg   <= wdata_next;
                be_reg      <= be_next;
                we_reg      <= i_Wen;
            end else if (state_reg == S_REQ || state_reg == S_WAIT_R) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (o_Fault || timeout_hit) begin
                rd_reg <= '0;
            end else if (capture) begin
                rd_reg <= load_ext;
            end
        end
    end

    assign o_Stall     = legal_req | (state_reg == S_REQ) | (state_reg == S_WAIT_R);
    assign o_Bus_valid = (state_reg == S_REQ);
    assign o_Bus_addr  = {addr_hi_reg, 2'b00};
    assign o_Bus_wdata = wdata_reg;
    assign o_Bus_be    = be_reg;
    assign o_Bus_we    = we_reg;
    assign o_Rd        = rd_reg;
    assign o_Timeout   = timeout_reg;

endmodule
